seq_divider_hs: RTL
===================

# seq_divider_hs

Parametrised iterative integer divider with ready/valid handshakes on both sides, selectable radix (1, 2 or 4 quotient bits per cycle) and a tag passthrough. It is the general-purpose successor to the single-radix, pulse-output divider. It sits between producers such as coordinate/scaling datapaths and consumers that may stall. Results are held until the consumer accepts them, so no result is ever dropped.

## Interface
- WIDTH, 32: operand and result width. Must be a multiple of RADIX_BITS and at least 4.
- RADIX_BITS, 1: quotient bits retired per cycle. Legal values are 1, 2 and 4. ITER = WIDTH/RADIX_BITS.
- TAG_WIDTH, 4: width of the opaque tag carried from input to output.

Ports (one clock; reset is synchronous and active-high):
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- dividend_in  input  WIDTH  dividend.
- divisor_in  input  WIDTH  divisor.
- tag_in  input  TAG_WIDTH  request tag.
- signed_in  input  1  treat operands as two's complement. Present only when DIVIDER_SIGNED_EN is defined.
- in_valid_in  input  1  request valid.
- in_ready_out  output  1  divider can accept a request.
- quotient_out  output  WIDTH  quotient.
- remainder_out  output  WIDTH  remainder.
- tag_out  output  TAG_WIDTH  tag of the current result.
- error_out  output  1  divide-by-zero flag; qualified by result_valid_out.
- result_valid_out  output  1  result valid.
- result_ready_in  input  1  consumer accepts the result.

## Operation
- States:
  - IDLE: in_ready_out=1.
  - DIVIDING: iterates the division.
  - DONE: result_valid_out=1.
- Accept: a request is taken on any edge where in_valid_in and in_ready_out are both high. The operands, tag and sign mode are captured at that edge. in_ready_out is 0 outside IDLE.
- IDLE -> DIVIDING on accept when divisor_in != 0. A down-counter is loaded with ITER.
- IDLE -> DONE on accept when divisor_in == 0. Result is quotient = all ones, remainder = dividend_in, error_out = 1.
- DIVIDING: each edge performs RADIX_BITS restoring-division steps combinationally.
  - The partial remainder is WIDTH+1 bits wide.
  - The comparison and subtraction are unsigned at WIDTH+1 bits.
  - When the counter reaches 1, the next edge moves to DONE.
- DONE: quotient_out, remainder_out, tag_out and error_out are held stable while result_valid_out=1 and result_ready_in=0.
  - On an edge with result_ready_in=1: go to IDLE and set result_valid_out=0.
- Result registers keep their last value after leaving DONE and are only meaningful while result_valid_out=1.
- in_valid_in asserted in a non-IDLE state is ignored; the producer must hold it.
- Reset value of every output is 0, except in_ready_out:
  - in_ready_out is 0 while rst_in is high.
  - in_ready_out is 1 on the first cycle after rst_in deasserts.
- A reset mid-division or mid-DONE aborts the operation. No result is emitted afterwards.

## Timing
- Accept at edge A (nonzero divisor): result_valid_out is high after edge A+ITER.
- Divide-by-zero: result_valid_out is high after edge A+1.
- If result_ready_in is already 1, result_valid_out is high for exactly one cycle. The next accept is possible at the edge after the DONE->IDLE edge.
- Throughput: one request per ITER+2 cycles with no backpressure.
- Outputs are registered. in_ready_out is decoded from the state register only, with no combinational path from any input.

## Configuration
- DIVIDER_SIGNED_EN defined:
  - The signed_in port exists.
  - When signed_in=1, the magnitudes of both operands are loaded at accept.
  - On the final iteration edge, the quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend. Division truncates toward zero.
  - Overflow case, most negative value / -1: quotient = most negative value, remainder = 0, error_out = 0.
  - Latency is unchanged.
  - Divide-by-zero behaves the same as unsigned: quotient = all ones, remainder = dividend.
- DIVIDER_SIGNED_EN not defined: the port is absent and all operations are unsigned.

## Test plan
- RADIX_BITS=1, WIDTH=32: 100/7 accepted at edge A -> valid after edge A+32, q=14, r=2, error=0, tag echoed.
- RADIX_BITS=4: 0xFFFFFFFF/0x10 -> valid after edge A+8, q=0x0FFFFFFF, r=0xF.
- 0x1234/0 -> valid after edge A+1, q=0xFFFFFFFF, r=0x1234, error=1.
- result_ready_in held low for 5 cycles after valid -> outputs stable, in_ready_out=0 throughout. Ready high -> IDLE next edge, and a back-to-back request is then accepted.
- rst_in pulsed at iteration 10 -> result_valid_out stays 0, in_ready_out=1 the cycle after reset, and a new 9/3 returns q=3, r=0.
- DIVIDER_SIGNED_EN, signed_in=1:
  - -7/2 -> q=-3, r=-1.
  - 7/-2 -> q=-3, r=1.
  - 0x80000000/-1 -> q=0x80000000, r=0, error=0.

Source files
------------

// File: rtl/seq_divider_hs_if.sv
// rtl/seq_divider_hs_if.sv - request/result handshake bundle for seq_divider_hs (signed_in exists only with DIVIDER_SIGNED_EN)
interface seq_divider_hs_if #(
    parameter int WIDTH     = 32,
    parameter int TAG_WIDTH = 4
);
    logic [WIDTH-1:0]     dividend_in;
    logic [WIDTH-1:0]     divisor_in;
    logic [TAG_WIDTH-1:0] tag_in;
`ifdef DIVIDER_SIGNED_EN
    logic                 signed_in;
`endif
    logic                 in_valid_in;
    logic                 in_ready_out;
    logic [WIDTH-1:0]     quotient_out;
    logic [WIDTH-1:0]     remainder_out;
    logic [TAG_WIDTH-1:0] tag_out;
    logic                 error_out;
    logic                 result_valid_out;
    logic                 result_ready_in;

    modport master (
        output dividend_in, divisor_in, tag_in,
`ifdef DIVIDER_SIGNED_EN
        output signed_in,
`endif
        output in_valid_in, result_ready_in,
        input  in_ready_out, quotient_out, remainder_out, tag_out, error_out, result_valid_out
    );

    modport slave (
        input  dividend_in, divisor_in, tag_in,
`ifdef DIVIDER_SIGNED_EN
        input  signed_in,
`endif
        input  in_valid_in, result_ready_in,
        output in_ready_out, quotient_out, remainder_out, tag_out, error_out, result_valid_out
    );
endinterface

// File: rtl/seq_divider_hs.sv
// rtl/seq_divider_hs.sv - iterative restoring divider, radix 2^RADIX_BITS, ready/valid both sides; DIVIDER_SIGNED_EN adds signed mode
module seq_divider_hs #(
    parameter int WIDTH      = 32,
    parameter int RADIX_BITS = 1,
    parameter int TAG_WIDTH  = 4
) (
    input logic             clk_in,
    input logic             rst_in,
    seq_divider_hs_if.slave bus
);
    localparam int ITER  = WIDTH / RADIX_BITS;
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, DIVIDING, DONE} state_t;

    state_t               state;
    logic [WIDTH:0]       rem_q;
    logic [WIDTH-1:0]     quo_q;
    logic [WIDTH-1:0]     div_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 neg_quo_q;
    logic                 neg_rem_q;

    logic [WIDTH:0]       rem_nx;
    logic [WIDTH-1:0]     quo_nx;
    logic [WIDTH-1:0]     quo_fin;
    logic [WIDTH-1:0]     rem_fin;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 accept;

`ifdef DIVIDER_SIGNED_EN
    assign a_neg = bus.signed_in & bus.dividend_in[WIDTH-1];
    assign b_neg = bus.signed_in & bus.divisor_in[WIDTH-1];
`else
    assign a_neg = 1'b0;
    assign b_neg = 1'b0;
`endif
    assign mag_a  = a_neg ? -bus.dividend_in : bus.dividend_in;
    assign mag_b  = b_neg ? -bus.divisor_in  : bus.divisor_in;
    assign accept = bus.in_valid_in & bus.in_ready_out;

    // quo_q doubles as the dividend shift register; quotient bits fill in from the bottom
    always_comb begin
        rem_nx = rem_q;
        quo_nx = quo_q;
        for (int i = 0; i < RADIX_BITS; i++) begin
            rem_nx = {rem_nx[WIDTH-1:0], quo_nx[WIDTH-1]};
            quo_nx = {quo_nx[WIDTH-2:0], 1'b0};
            if (rem_nx >= {1'b0, div_q}) begin
                rem_nx    = rem_nx - {1'b0, div_q};
                quo_nx[0] = 1'b1;
            end
        end
    end

    assign quo_fin = neg_quo_q ? -quo_nx : quo_nx;
    assign rem_fin = neg_rem_q ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state                <= IDLE;
            rem_q                <= '0;
            quo_q                <= '0;
            div_q                <= '0;
            cnt_q                <= '0;
            tag_q                <= '0;
            neg_quo_q            <= 1'b0;
            neg_rem_q            <= 1'b0;
            bus.in_ready_out     <= 1'b0;
            bus.quotient_out     <= '0;
            bus.remainder_out    <= '0;
            bus.tag_out          <= '0;
            bus.error_out        <= 1'b0;
            bus.result_valid_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.in_ready_out <= 1'b1;
                    if (accept) begin
                        bus.in_ready_out <= 1'b0;
                        if (bus.divisor_in == '0) begin
                            // result is loaded now; valid follows on the next edge
                            bus.quotient_out  <= '1;
                            bus.remainder_out <= bus.dividend_in;
                            bus.tag_out       <= bus.tag_in;
                            bus.error_out     <= 1'b1;
                            state             <= DONE;
                        end else begin
                            rem_q     <= '0;
                            quo_q     <= mag_a;
                            div_q     <= mag_b;
                            cnt_q     <= CNT_W'(ITER);
                            tag_q     <= bus.tag_in;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            state     <= DIVIDING;
                        end
                    end
                end
                DIVIDING: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        bus.quotient_out     <= quo_fin;
                        bus.remainder_out    <= rem_fin;
                        bus.tag_out          <= tag_q;
                        bus.error_out        <= 1'b0;
                        bus.result_valid_out <= 1'b1;
                        state                <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.result_valid_out) begin
                        bus.result_valid_out <= 1'b1;
                    end else if (bus.result_ready_in) begin
                        bus.result_valid_out <= 1'b0;
                        bus.in_ready_out     <= 1'b1;
                        state                <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
